board_frame_buffer: RTL and testbench
=====================================

# board_frame_buffer

Double-buffered 32x32 board store between the SPI board deserializer and the LED matrix driver. Raster-ordered 2-bit pixels from the deserializer fill the back bank. A completed frame swaps to the front only at the matrix driver's refresh boundary, so a refresh never shows a half-written board. The matrix driver reads the front bank by row/column with one-cycle latency.

## Interface
- ROWS, 32, board rows; power of two
- COLS, 32, board columns; power of two
- PIX_W, 2, bits per pixel (colour code)
- clk  in  1  system clock; every port is synchronous to it
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  write pixel offered
- wr_ready  out  1  back bank accepts pixel; a pixel is taken when wr_valid && wr_ready
- wr_pix  in  PIX_W  pixel value, raster order (row 0 col 0 first)
- wr_last  in  1  marks the final pixel of a frame; sampled only on an accepted beat
- vsync  in  1  one-cycle pulse from the matrix driver at the start of a refresh (before row 0 is read)
- rd_en  in  1  read request
- rd_row  in  log2(ROWS)  read row
- rd_col  in  log2(COLS)  read column
- rd_pix  out  PIX_W  read data
- rd_valid  out  1  rd_pix is valid (rd_en delayed one cycle)
- front_sel  out  1  bank currently displayed
- frame_count  out  8  count of swapped frames, wraps at 255
- err_short  out  1  one-cycle pulse: wr_last arrived before the frame was full

## Operation
- State machine with two states: FILL and PENDING. Write pointer wp is 10 bits (ROWS*COLS-1 max).
- FILL:
  - wr_ready=1.
  - An accepted beat writes wr_pix to back[wp].
  - If wp==ROWS*COLS-1: wp←0, go to PENDING. wr_last is expected here, but its absence is not an error.
  - Else if wr_last: wp←0, err_short pulses, stay in FILL. Pixels already written stay in the back bank and are overwritten by the next frame; no swap occurs.
  - Else: wp←wp+1.
- PENDING:
  - wr_ready=0; no writes occur.
  - On vsync: front_sel←~front_sel, frame_count←frame_count+1, shown←1, go to FILL.
- Read path:
  - On rd_en: rd_pix←(shown ? front[rd_row*COLS+rd_col] : 0) and rd_valid←1.
  - Otherwise rd_valid←0 and rd_pix holds its value.
- Until the first swap (shown=0) the display reads colour 0. Bank contents are never reset.

## Timing
- Reset values: state FILL, wp 0, front_sel 0, shown 0, frame_count 0, rd_pix 0, rd_valid 0, err_short 0, wr_ready 1 (combinational from state).
- Write: a pixel accepted at edge N is readable from the back bank only after a swap.
- Swap:
  - PENDING is entered at the edge that accepts the last pixel.
  - A vsync in that same cycle is ignored because the state was still FILL; the swap waits for the next vsync.
  - A vsync in PENDING at edge N changes front_sel after edge N.
  - A read issued in cycle N uses the old front bank; a read in cycle N+1 uses the new one.
- Read latency is exactly 1 cycle. A new read may be issued every cycle.
- vsync in FILL has no effect.
- err_short and the swap are mutually exclusive by construction.
- Reset asserted mid-frame discards the partial frame and drops the current display back to colour 0 (shown←0).

## Structure
- The shared package tetris_pkg holds:
  - BOARD_ROWS=32 and BOARD_COLS=32
  - pix_t, a PIX_W-bit enum: 0 empty, 1 white, 2 red, 3 blue
  - a function that turns row/column into a flat address
- Sub-module fb_bank: ROWS*COLS x PIX_W storage with one write port and a registered read port, instantiated twice. Bank select and the write-enable steering stay in board_frame_buffer.

## Test plan
- Full frame swap: reset, then write 1024 pixels with value (addr mod 4), wr_last on the final one → state PENDING and wr_ready=0. Pulse vsync → front_sel=1, frame_count=1. Read (3,5) → rd_pix=(3*32+5) mod 4=1, one cycle after rd_en.
- Read before any frame: after reset, read (0,0) and (31,31) → rd_pix=0 and rd_valid=1 one cycle later, even when the banks are preloaded with 3.
- Short frame: write 500 pixels, wr_last on the 500th → err_short pulses once, state stays FILL, no swap on vsync. Then a full 1024-pixel frame swaps normally with frame_count=1.
- Backpressure and vsync coincidence: assert vsync in the same cycle as the 1024th write → no swap. Hold wr_valid high in PENDING → no writes (front data unchanged) until the next vsync swaps.
- Swap-cycle read: issue rd_en to (0,0) in the vsync cycle and the following cycle, with old=2 and new=1 → rd_pix=2 then 1.
- Mid-frame reset: reset after 300 pixels → all outputs at their reset values. A full frame afterwards swaps correctly and the counter reads 1.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board definitions: dimensions, pixel colour codes, frame buffer
// FSM states and a row/column to flat address helper.
package tetris_pkg;

  localparam int BOARD_ROWS  = 32;
  localparam int BOARD_COLS  = 32;
  localparam int BOARD_PIX_W = 2;
  localparam int BOARD_ROW_W = $clog2(BOARD_ROWS);
  localparam int BOARD_COL_W = $clog2(BOARD_COLS);
  localparam int BOARD_ADDR_W = $clog2(BOARD_ROWS * BOARD_COLS);

  // Colour code stored per board cell.
  typedef enum logic [BOARD_PIX_W-1:0] {
    PIX_EMPTY = 2'd0,
    PIX_WHITE = 2'd1,
    PIX_RED   = 2'd2,
    PIX_BLUE  = 2'd3
  } pix_t;

  // Frame buffer write-side state: filling the back bank, or holding a
  // complete back bank until the display reaches a refresh boundary.
  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PENDING = 1'b1
  } fb_state_t;

  // Raster address of a board cell (row-major, row 0 col 0 first).
  function automatic logic [BOARD_ADDR_W-1:0] flat_addr(
    input logic [BOARD_ROW_W-1:0] row,
    input logic [BOARD_COL_W-1:0] col
  );
    logic [BOARD_ADDR_W-1:0] a;
    a = BOARD_ADDR_W'(row) * BOARD_ADDR_W'(BOARD_COLS) + BOARD_ADDR_W'(col);
    return a;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One board bank: single write port, registered read port.
// Contents are not reset; the read register only updates on rd_en so the
// last read value is held between requests.
module fb_bank #(
  parameter int DEPTH = 1024,
  parameter int PIX_W = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/board_frame_buffer.sv
// Double-buffered board store. The deserializer fills the back bank in
// raster order; a completed frame becomes the front bank only on vsync so
// the matrix driver never shows a half-written board.
//
// Handshake: a pixel is transferred on a rising edge where wr_valid and
// wr_ready are both high. wr_ready depends only on state (never on
// wr_valid), the producer may hold wr_valid high while wr_ready is low, and
// wr_pix/wr_last are only looked at on a transferring edge.
module board_frame_buffer
  import tetris_pkg::*;
#(
  parameter int ROWS  = BOARD_ROWS,
  parameter int COLS  = BOARD_COLS,
  parameter int PIX_W = BOARD_PIX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [PIX_W-1:0]        wr_pix,
  input  logic                    wr_last,
  input  logic                    vsync,
  input  logic                    rd_en,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [PIX_W-1:0]        rd_pix,
  output logic                    rd_valid,
  output logic                    front_sel,
  output logic [7:0]              frame_count,
  output logic                    err_short,
  output fb_state_t               dbg_state
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] WP_LAST = AW'(DEPTH - 1);

  fb_state_t        state, state_nxt;
  logic [AW-1:0]    wp;
  logic             shown;
  logic             accept;
  logic             frame_full;
  logic             swap;
  logic             we0, we1;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] bank0_q, bank1_q;
  logic             rd_sel_q;
  logic             rd_shown_q;

  assign accept     = wr_valid && wr_ready;
  assign frame_full = (wp == WP_LAST);
  assign swap       = (state == ST_PENDING) && vsync;
  assign dbg_state  = state;

  // Banks are addressed row-major; both dimensions are powers of two.
  assign rd_addr = {rd_row, rd_col};

  // The back bank is the one not on display.
  assign we0 = accept && front_sel;
  assign we1 = accept && !front_sel;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and write-side ready.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      ST_FILL: begin
        wr_ready = 1'b1;
        if (accept && frame_full) begin
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (vsync) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // Write pointer, short-frame error pulse and swap bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp          <= '0;
      err_short   <= 1'b0;
      front_sel   <= 1'b0;
      frame_count <= 8'd0;
      shown       <= 1'b0;
    end else begin
      err_short <= 1'b0;
      if (accept) begin
        if (frame_full) begin
          wp <= '0;
        end else if (wr_last) begin
          wp        <= '0;
          err_short <= 1'b1;
        end else begin
          wp <= wp + AW'(1);
        end
      end
      if (swap) begin
        front_sel   <= ~front_sel;
        frame_count <= frame_count + 8'd1;
        shown       <= 1'b1;
      end
    end
  end

  fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W)) u_bank0 (
    .clk     (clk),
    .we      (we0),
    .wr_addr (wp),
    .wr_data (wr_pix),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bank0_q)
  );

  fb_bank #(.DEPTH(DEPTH), .PIX_W(PIX_W)) u_bank1 (
    .clk     (clk),
    .we      (we1),
    .wr_addr (wp),
    .wr_data (wr_pix),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (bank1_q)
  );

  // Capture which bank was on display (and whether any frame was) alongside
  // the bank read, so rd_pix reflects the front bank at request time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_shown_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel_q   <= front_sel;
        rd_shown_q <= shown;
      end
    end
  end

  // Read data mux; blank until the first frame has been swapped in.
  always_comb begin
    rd_pix = '0;
    if (rd_shown_q) begin
      rd_pix = rd_sel_q ? bank1_q : bank0_q;
    end
  end

endmodule

// File: tb/tb_board_frame_buffer.sv
// Directed bench for board_frame_buffer: full-frame swaps, blank display
// before the first swap, short frames, backpressure with coincident vsync,
// swap-cycle reads and mid-frame reset.
module tb_board_frame_buffer;
  import tetris_pkg::*;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_pix;
  logic       wr_last;
  logic       vsync;
  logic       rd_en;
  logic [4:0] rd_row;
  logic [4:0] rd_col;
  logic [1:0] rd_pix;
  logic       rd_valid;
  logic       front_sel;
  logic [7:0] frame_count;
  logic       err_short;
  fb_state_t  dbg_state;

  int n_asserts;
  int n_fails;

  board_frame_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_pix      (wr_pix),
    .wr_last     (wr_last),
    .vsync       (vsync),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_pix      (rd_pix),
    .rd_valid    (rd_valid),
    .front_sel   (front_sel),
    .frame_count (frame_count),
    .err_short   (err_short),
    .dbg_state   (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write n pixels. mode 0: constant v; mode 1: address mod 4.
  // wr_last on the final beat if last; vsync on the final beat if vs_last.
  task automatic write_frame(input int n, input int mode, input logic [1:0] v,
                             input bit last, input bit vs_last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_pix   = (mode == 1) ? 2'(i % 4) : v;
      wr_last  = last && (i == n - 1);
      vsync    = vs_last && (i == n - 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    vsync    = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] r, input logic [4:0] c,
                            input logic [1:0] exp);
    rd_en  = 1'b1;
    rd_row = r;
    rd_col = c;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_pix), 32'(exp));
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    vsync    = 1'b0;
    rd_en    = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       32'(dbg_state),   32'(ST_FILL));
    check({tag, "_wr_ready"},    32'(wr_ready),    32'd1);
    check({tag, "_front_sel"},   32'(front_sel),   32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_rd_pix"},      32'(rd_pix),      32'd0);
    check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
    check({tag, "_err_short"},   32'(err_short),   32'd0);
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_pix    = 2'd0;
    wr_last   = 1'b0;
    vsync     = 1'b0;
    rd_en     = 1'b0;
    rd_row    = 5'd0;
    rd_col    = 5'd0;

    // Reset values.
    do_reset();
    reset = 1'b1;
    check_reset_values("rst");

    // Read before any frame: blank.
    read_check("pre_rd00", 5'd0, 5'd0, 2'd0);
    read_check("pre_rd3131", 5'd31, 5'd31, 2'd0);
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);

    // Full frame of 3s into back bank with vsync on the final beat: no swap.
    write_frame(1024, 0, 2'd3, 1'b1, 1'b1);
    check("coinc_state", 32'(dbg_state), 32'(ST_PENDING));
    check("coinc_ready", 32'(wr_ready), 32'd0);
    check("coinc_front", 32'(front_sel), 32'd0);
    check("coinc_count", 32'(frame_count), 32'd0);
    read_check("preload_rd", 5'd3, 5'd5, 2'd0);

    // Backpressure: wr_valid held in PENDING with value 0, nothing written.
    wr_valid = 1'b1;
    wr_pix   = 2'd0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    pulse_vsync();
    check("swap1_front", 32'(front_sel), 32'd1);
    check("swap1_count", 32'(frame_count), 32'd1);
    check("swap1_state", 32'(dbg_state), 32'(ST_FILL));
    read_check("swap1_rd35", 5'd3, 5'd5, 2'd3);
    read_check("swap1_rd00", 5'd0, 5'd0, 2'd3);

    // Full frame of address mod 4.
    write_frame(1024, 1, 2'd0, 1'b1, 1'b0);
    check("full_state", 32'(dbg_state), 32'(ST_PENDING));
    pulse_vsync();
    check("swap2_front", 32'(front_sel), 32'd0);
    check("swap2_count", 32'(frame_count), 32'd2);
    read_check("swap2_rd35", 5'd3, 5'd5, 2'(flat_addr(5'd3, 5'd5) % 4));
    read_check("swap2_rd3131", 5'd31, 5'd31, 2'd3);
    read_check("swap2_rd02", 5'd0, 5'd2, 2'd2);

    // Short frame: 500 pixels, wr_last on the 500th.
    write_frame(500, 0, 2'd1, 1'b1, 1'b0);
    check("short_err", 32'(err_short), 32'd1);
    check("short_state", 32'(dbg_state), 32'(ST_FILL));
    tick();
    check("short_err_drop", 32'(err_short), 32'd0);
    pulse_vsync();
    check("short_front", 32'(front_sel), 32'd0);
    check("short_count", 32'(frame_count), 32'd2);
    read_check("short_rd35", 5'd3, 5'd5, 2'd1);

    // Full frame of 2s after the short one swaps normally.
    write_frame(1024, 0, 2'd2, 1'b1, 1'b0);
    check("after_short_err", 32'(err_short), 32'd0);
    pulse_vsync();
    check("swap3_front", 32'(front_sel), 32'd1);
    check("swap3_count", 32'(frame_count), 32'd3);
    read_check("swap3_rd00", 5'd0, 5'd0, 2'd2);
    read_check("swap3_rd1020", 5'd10, 5'd20, 2'd2);

    // Swap-cycle read: old front holds 2, new frame holds 1.
    write_frame(1024, 0, 2'd1, 1'b1, 1'b0);
    check("sc_state", 32'(dbg_state), 32'(ST_PENDING));
    vsync  = 1'b1;
    rd_en  = 1'b1;
    rd_row = 5'd0;
    rd_col = 5'd0;
    tick();
    vsync = 1'b0;
    check("sc_rd_old", 32'(rd_pix), 32'd2);
    check("sc_front", 32'(front_sel), 32'd0);
    tick();
    rd_en = 1'b0;
    check("sc_rd_new", 32'(rd_pix), 32'd1);
    check("sc_count", 32'(frame_count), 32'd4);
    // rd_pix holds while idle.
    tick();
    check("sc_hold", 32'(rd_pix), 32'd1);

    // Mid-frame reset after 300 pixels.
    write_frame(300, 0, 2'd3, 1'b0, 1'b0);
    do_reset();
    check_reset_values("mid_rst_in");
    reset = 1'b1;
    tick();
    check_reset_values("mid_rst_out");
    read_check("mid_rst_rd", 5'd0, 5'd0, 2'd0);
    write_frame(1024, 1, 2'd0, 1'b1, 1'b0);
    pulse_vsync();
    check("mid_swap_front", 32'(front_sel), 32'd1);
    check("mid_swap_count", 32'(frame_count), 32'd1);
    read_check("mid_swap_rd35", 5'd3, 5'd5, 2'(flat_addr(5'd3, 5'd5) % 4));
    read_check("mid_swap_rd01", 5'd0, 5'd1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
